// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared types and constants for the sequential divider.
//   state_t        FSM encoding {IDLE, RUN, DONE}, 2 bits
//   DIV0_QUOTIENT  all-ones quotient returned on divide-by-zero (slice to WIDTH)
//   cnt_w()        iteration counter width for a given operand width
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_WIDTH = 16;
  localparam logic [MAX_WIDTH-1:0] DIV0_QUOTIENT = '1;

  // Counter only has to hold WIDTH-1; keep at least one bit for WIDTH=2.
  function automatic int cnt_w(input int w);
    return (w < 3) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: start/done handshake and operand/result bus of the divider.
//   master: controller side (drives start/dividend/divisor)
//   slave : divider side (drives busy/done/quotient/remainder/div_by_zero)
interface seq_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_addsub.sv
// addsub_stage: W-bit ripple adder/subtractor.
//   a, b  operands
//   mode  0 = add, 1 = subtract (b inverted, carry-in = 1)
//   sum   result
//   cout  carry out; in subtract mode 1 means no borrow (a >= b)
module addsub_stage #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         mode,
  output logic [W-1:0] sum,
  output logic         cout
);
  always_comb begin
    logic cy;
    logic bx;
    cy  = mode;
    sum = '0;
    for (int i = 0; i < W; i++) begin
      bx     = b[i] ^ mode;
      sum[i] = a[i] ^ bx ^ cy;
      cy     = (a[i] & bx) | (cy & (a[i] ^ bx));
    end
    cout = cy;
  end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: restoring divider, one quotient bit per clock.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; aborts any operation in flight
//   bus    seq_divider_if.slave: start/dividend/divisor in,
//          busy/done/quotient/remainder/div_by_zero out
// Optional: define SEQ_DIVIDER_SIGNED_EN for two's-complement operands
// (magnitudes run through the unsigned core, signs fixed up on exit).
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_divider_if.slave   bus
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q_sh, dvs;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   shifted, trial, acc_nxt;
  logic             no_borrow;
  logic [WIDTH-1:0] q_nxt, r_nxt, q_fin, r_fin;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic             accept;

  assign accept = (state_q == IDLE) && bus.start;

  // Trial subtract: shifted - {0, dvs}.
  assign shifted = {acc[WIDTH-1:0], q_sh[WIDTH-1]};

  addsub_stage #(.W(WIDTH + 1)) u_sub (
    .a    (shifted),
    .b    ({1'b0, dvs}),
    .mode (1'b1),
    .sum  (trial),
    .cout (no_borrow)
  );

  assign acc_nxt = no_borrow ? trial : shifted;
  assign q_nxt   = {q_sh[WIDTH-2:0], no_borrow};
  assign r_nxt   = acc_nxt[WIDTH-1:0];

  // Top acc bit is a guard against overflow of the trial subtract; after a
  // restore step it is always zero, so nothing downstream reads it.
  logic unused_top;
  assign unused_top = acc[WIDTH] ^ trial[WIDTH];

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic q_neg, r_neg;
  assign a_abs = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign b_abs = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
  // Most-negative / -1 falls out naturally: |MIN| = MIN as unsigned, no negate.
  assign q_fin = q_neg ? -q_nxt : q_nxt;
  assign r_fin = r_neg ? -r_nxt : r_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (accept) begin
      q_neg <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      r_neg <= bus.dividend[WIDTH-1];
    end
  end
`else
  assign a_abs = bus.dividend;
  assign b_abs = bus.divisor;
  assign q_fin = q_nxt;
  assign r_fin = r_nxt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = (bus.divisor == '0) ? DONE : RUN;
      RUN:     if (cnt == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);

  // Results are written on the edge that enters DONE, so they are valid
  // in the done cycle and held until the next operation finishes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc             <= '0;
      q_sh            <= '0;
      dvs             <= '0;
      cnt             <= '0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          if (bus.divisor == '0) begin
            bus.quotient    <= DIV0_QUOTIENT[WIDTH-1:0];
            bus.remainder   <= bus.dividend;
            bus.div_by_zero <= 1'b1;
          end else begin
            acc  <= '0;
            q_sh <= a_abs;
            dvs  <= b_abs;
            cnt  <= CNT_INIT;
          end
        end
        RUN: begin
          acc  <= acc_nxt;
          q_sh <= q_nxt;
          cnt  <= cnt - CW'(1);
          if (cnt == '0) begin
            bus.quotient    <= q_fin;
            bus.remainder   <= r_fin;
            bus.div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
